alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 4-bit combinational ALU.
- Provides WIDTH-bit operands, valid/ready handshakes on input and output, a full flag set (carry, zero, negative, overflow) and an iterative shift-add multiply.
- Sits between an operand-issue stage and a result-writeback stage; one operation in flight at a time.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).
- SHW, $clog2(WIDTH), width of the counter used for the multiply iterations.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  block can accept an operation this cycle.
- op  input  3  operation select (see Behaviour).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  registered result.
- carry  output  1  carry-out / borrow / multiply-overflow.
- zero  output  1  result == 0.
- neg  output  1  result[WIDTH-1].
- ovf  output  1  signed overflow (ADD/SUB only).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; out_valid, result, carry, zero, neg and ovf all 0.
- Reset applied mid-multiply or with a result pending aborts the operation and discards the result; no out_valid follows.
- Opcodes (encodings 000-100 match the previous-generation ALU):
  - 000 ADD: {carry,result} = a + b.
  - 001 SUB: {carry,result} = a - b, so carry = 1 on borrow (a < b unsigned).
  - 010 AND, 011 OR, 100 XOR: carry = 0.
  - 101 SHL: a << b. If b >= WIDTH, result = 0. carry = 0.
  - 110 SHR: a >> b (logical). If b >= WIDTH, result = 0. carry = 0.
  - 111 MUL: result = low WIDTH bits of a*b (unsigned); carry = 1 if the high WIDTH bits are nonzero.
- Flags:
  - ovf: for ADD it is 1 when a and b have the same sign and the result sign differs; for SUB it is 1 when a and b differ in sign and the result sign differs from a. ovf = 0 for all other ops.
  - zero and neg are computed from the final result for every op.
- Handshake:
  - An input is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready), so back-to-back single-cycle ops sustain 1 op per cycle.
  - op, a and b are sampled only on accept; the bench may change them at any other time.
  - result and flags are held stable while out_valid && !out_ready.
- States:
  - IDLE: on accept of a non-MUL op, register result/flags and go to DONE. On accept of MUL, latch the operands, clear the accumulator and counter, and go to MUL.
  - MUL: one shift-add step per cycle for WIDTH cycles (counter 0..WIDTH-1). After the last step, register result/flags and go to DONE. in_ready = 0 throughout.
  - DONE: out_valid = 1. If out_ready is high and a new op is accepted in the same cycle, take the IDLE accept path. If out_ready is high with no accept, go to IDLE and drop out_valid. Otherwise hold.
- Latency (accept in cycle N):
  - Non-MUL: out_valid high in cycle N+1.
  - MUL: out_valid high in cycle N+WIDTH+1.
- Simultaneous events: rst has priority over everything. A consume and an accept in the same DONE cycle are both legal and lose no data.

Decomposition:
- alu_pkg:
  - alu_op_e enum (ADD, SUB, AND, OR, XOR, SHL, SHR, MUL).
  - alu_state_e enum (IDLE, MUL, DONE).
  - Flag bit-index constants.
- Sub-module alu_mul_serial: holds the shift-add datapath and the counter.
  - Interface: start, a, b, busy, done, a 2*WIDTH product.
- The top module owns the FSM, the handshake and flag generation.

Test Plan:
- WIDTH=8, ADD a=0xFF, b=0x01 -> result 0x00, carry 1, zero 1, neg 0, ovf 0; out_valid exactly 1 cycle after accept.
- SUB a=0x05, b=0x07 -> result 0xFE, carry 1, neg 1, ovf 0. ADD a=0x7F, b=0x01 -> 0x80, ovf 1, neg 1, carry 0.
- MUL a=0x0F, b=0x11 -> 0xFF, carry 0, out_valid 9 cycles after accept. MUL a=0x10, b=0x10 -> 0x00, carry 1, zero 1. in_ready stays 0 during the multiply.
- SHL a=0x81, b=1 -> 0x02. SHR a=0x81, b=3 -> 0x10. SHL a=0xFF, b=8 -> 0x00, zero 1.
- Backpressure: hold out_ready=0 for 3 cycles after an XOR a=0xF0, b=0x3C result 0xCC -> result/flags stable, in_ready 0. Then with out_ready=1 and a new AND issued in the same cycle -> the AND is accepted and its result appears next cycle.
- Streaming and reset: issue 4 back-to-back ADDs with out_ready=1 -> 4 consecutive valid results, no bubbles. Assert rst at cycle 4 of a MUL -> next cycle IDLE, all outputs 0, and no stale out_valid afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state enums plus
// bit positions of the packed flag register.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    localparam int FLAG_C    = 0;
    localparam int FLAG_Z    = 1;
    localparam int FLAG_N    = 2;
    localparam int FLAG_V    = 3;
    localparam int NUM_FLAGS = 4;

endpackage

// File: rtl/alu_mul_serial.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// WIDTH cycles per operation, product presented during the final step.
module alu_mul_serial #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     step_cnt;

    always_comb begin
        acc_next = mplier[0] ? (acc + mcand) : acc;
    end

    // The product includes the last step's contribution, so the owner can
    // register it in the same cycle that done is high.
    assign done    = busy && (step_cnt == LAST_STEP);
    assign product = acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            step_cnt <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            step_cnt <= '0;
            acc      <= '0;
            mcand    <= {{WIDTH{1'b0}}, a};
            mplier   <= b;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (done) begin
                busy <= 1'b0;
            end else begin
                step_cnt <= step_cnt + SHW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides; single-cycle ops
// stream at one per clock, MUL is delegated to the serial multiplier.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               carry,
    output logic               zero,
    output logic               neg,
    output logic               ovf
);

    localparam logic [WIDTH-1:0] WIDTH_LIM = WIDTH'(WIDTH);

    alu_state_e           state;
    logic [NUM_FLAGS-1:0] flags;

    logic                 accept;
    logic                 mul_start;
    logic                 mul_busy;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;

    logic [WIDTH:0]       wide;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_carry;
    logic                 alu_ovf;
    logic [NUM_FLAGS-1:0] alu_flags;
    logic [NUM_FLAGS-1:0] mul_flags;

    // A result being consumed frees the slot, so DONE can accept in the same cycle.
    assign in_ready  = !mul_busy && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (alu_op_e'(op) == OP_MUL);

    alu_mul_serial #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        wide      = '0;
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (alu_op_e'(op))
            OP_ADD: begin
                wide      = {1'b0, a} + {1'b0, b};
                alu_res   = wide[WIDTH-1:0];
                alu_carry = wide[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                wide      = {1'b0, a} - {1'b0, b};
                alu_res   = wide[WIDTH-1:0];
                alu_carry = wide[WIDTH];
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SHL:  alu_res = (b >= WIDTH_LIM) ? '0 : (a << b);
            OP_SHR:  alu_res = (b >= WIDTH_LIM) ? '0 : (a >> b);
            default: alu_res = '0;
        endcase

        alu_flags         = '0;
        alu_flags[FLAG_C] = alu_carry;
        alu_flags[FLAG_Z] = (alu_res == '0);
        alu_flags[FLAG_N] = alu_res[WIDTH-1];
        alu_flags[FLAG_V] = alu_ovf;

        // Multiply carry reports any lost high-half bits.
        mul_flags         = '0;
        mul_flags[FLAG_C] = |mul_product[2*WIDTH-1:WIDTH];
        mul_flags[FLAG_Z] = (mul_product[WIDTH-1:0] == '0);
        mul_flags[FLAG_N] = mul_product[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (accept) begin
            if (mul_start) begin
                state     <= MUL;
                out_valid <= 1'b0;
            end else begin
                result    <= alu_res;
                flags     <= alu_flags;
                state     <= DONE;
                out_valid <= 1'b1;
            end
        end else begin
            case (state)
                IDLE: ;
                MUL: begin
                    if (mul_done) begin
                        result    <= mul_product[WIDTH-1:0];
                        flags     <= mul_flags;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign carry = flags[FLAG_C];
    assign zero  = flags[FLAG_Z];
    assign neg   = flags[FLAG_N];
    assign ovf   = flags[FLAG_V];

endmodule
